// File: rtl/inst_encoder_pkg.sv
// Shared encode/decode tables for the MIPS ALU subset: one-hot op indices, funct and opcode constants.
package inst_encoder_pkg;

    localparam int unsigned AluopWidth = 14;
    localparam int unsigned InstWidth  = 32;
    localparam int unsigned RegAddrW   = 5;

    typedef logic [AluopWidth-1:0] Aluop_OnehotBus;
    typedef logic [InstWidth-1:0]  InstBus;
    typedef logic [RegAddrW-1:0]   RegAddrBus;
    typedef logic [5:0]            FunctBus;

    localparam InstBus ZeroWord = 32'h0000_0000;

    localparam int unsigned AluopAdd  = 13;
    localparam int unsigned AluopAddu = 12;
    localparam int unsigned AluopSub  = 11;
    localparam int unsigned AluopSubu = 10;
    localparam int unsigned AluopSlt  = 9;
    localparam int unsigned AluopSltu = 8;
    localparam int unsigned AluopAnd  = 7;
    localparam int unsigned AluopOr   = 6;
    localparam int unsigned AluopXor  = 5;
    localparam int unsigned AluopNor  = 4;
    localparam int unsigned AluopSll  = 3;
    localparam int unsigned AluopSrl  = 2;
    localparam int unsigned AluopSra  = 1;
    localparam int unsigned AluopLui  = 0;

    localparam FunctBus FuncAdd  = 6'h20;
    localparam FunctBus FuncAddu = 6'h21;
    localparam FunctBus FuncSub  = 6'h22;
    localparam FunctBus FuncSubu = 6'h23;
    localparam FunctBus FuncAnd  = 6'h24;
    localparam FunctBus FuncOr   = 6'h25;
    localparam FunctBus FuncXor  = 6'h26;
    localparam FunctBus FuncNor  = 6'h27;
    localparam FunctBus FuncSlt  = 6'h2A;
    localparam FunctBus FuncSltu = 6'h2B;
    localparam FunctBus FuncSll  = 6'h00;
    localparam FunctBus FuncSrl  = 6'h02;
    localparam FunctBus FuncSra  = 6'h03;

    localparam logic [5:0] OpZero = 6'b000000;
    localparam logic [5:0] OpLui  = 6'b001111;

    // Legal ops have exactly one bit set.
    function automatic logic is_onehot(input Aluop_OnehotBus v);
        return (v != '0) && ((v & (v - Aluop_OnehotBus'(1))) == '0);
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous instruction FIFO with occupancy count and active-low synchronous reset.
module inst_fifo
    import inst_encoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  InstBus                   wdata,
    input  logic                     pop,
    output InstBus                   rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    InstBus        mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/inst_encoder.sv
// Assembles one-hot ALU op requests into MIPS instruction words and issues them through a FIFO.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  Aluop_OnehotBus         aluop_i,
    input  RegAddrBus              rs_i,
    input  RegAddrBus              rt_i,
    input  RegAddrBus              rd_i,
    input  logic [4:0]             sa_i,
    input  logic [15:0]            imm_i,
    output logic                   inst_valid_o,
    input  logic                   inst_ready_i,
    output InstBus                 inst_o,
    output logic                   err_o,
    output logic [$clog2(DEPTH):0] count_o
);

    function automatic FunctBus funct_of(input Aluop_OnehotBus op);
        FunctBus f;
        f = FuncSll;
        if      (op[AluopAdd])  f = FuncAdd;
        else if (op[AluopAddu]) f = FuncAddu;
        else if (op[AluopSub])  f = FuncSub;
        else if (op[AluopSubu]) f = FuncSubu;
        else if (op[AluopSlt])  f = FuncSlt;
        else if (op[AluopSltu]) f = FuncSltu;
        else if (op[AluopAnd])  f = FuncAnd;
        else if (op[AluopOr])   f = FuncOr;
        else if (op[AluopXor])  f = FuncXor;
        else if (op[AluopNor])  f = FuncNor;
        else if (op[AluopSrl])  f = FuncSrl;
        else if (op[AluopSra])  f = FuncSra;
        return f;
    endfunction

    // Only called for legal (one-hot) ops; unused fields are forced to zero per format.
    function automatic InstBus encode(input Aluop_OnehotBus op, input RegAddrBus rs,
                                      input RegAddrBus rt, input RegAddrBus rd,
                                      input logic [4:0] sa, input logic [15:0] imm);
        InstBus w;
        if (op[AluopLui])
            w = {OpLui, 5'b00000, rt, imm};
        else if (op[AluopSll] || op[AluopSrl] || op[AluopSra])
            w = {OpZero, 5'b00000, rt, rd, sa, funct_of(op)};
        else
            w = {OpZero, rs, rt, rd, 5'b00000, funct_of(op)};
        return w;
    endfunction

    logic   legal_c;
    logic   accept_c;
    logic   push_c;
    logic   pop_c;
    logic   full;
    logic   empty;
    InstBus head;
    InstBus word_c;

    assign legal_c  = is_onehot(aluop_i);
    assign accept_c = req_valid_i && req_ready_o;
    assign push_c   = accept_c && legal_c;
    assign pop_c    = inst_valid_o && inst_ready_i;
    assign word_c   = encode(aluop_i, rs_i, rt_i, rd_i, sa_i, imm_i);

    inst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .wdata (word_c),
        .pop   (pop_c),
        .rdata (head),
        .count (count_o),
        .full  (full),
        .empty (empty)
    );

    assign req_ready_o  = !full;
    assign inst_valid_o = !empty;
    assign inst_o       = empty ? ZeroWord : head;

    always_ff @(posedge clk) begin
        if (!rst) err_o <= 1'b0;
        else      err_o <= accept_c && !legal_c;
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vector table, corner sequences, random vs. queue model.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [13:0] aluop_i;
    logic [4:0]  rs_i, rt_i, rd_i, sa_i;
    logic [15:0] imm_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic        err_o;
    logic [2:0]  count_o;

    int tests = 0;
    int fails = 0;

    inst_encoder #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .aluop_i      (aluop_i),
        .rs_i         (rs_i),
        .rt_i         (rt_i),
        .rd_i         (rd_i),
        .sa_i         (sa_i),
        .imm_i        (imm_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .err_o        (err_o),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] op;
        logic [4:0]  rs, rt, rd, sa;
        logic [15:0] imm;
        logic [31:0] word;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic [13:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sa,
                           input logic [15:0] imm);
        req_valid_i = v; aluop_i = op; rs_i = rs; rt_i = rt; rd_i = rd; sa_i = sa; imm_i = imm;
    endtask

    function automatic int popcount14(input logic [13:0] v);
        int n = 0;
        for (int i = 0; i < 14; i++) n += int'(v[i]);
        return n;
    endfunction

    // Reference word built from the field layout of each instruction class.
    function automatic logic [31:0] model_word(input logic [13:0] op, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [4:0] rd,
                                               input logic [4:0] sa, input logic [15:0] imm);
        int funct_tab[14] = '{0, 3, 2, 0, 'h27, 'h26, 'h25, 'h24, 'h2B, 'h2A, 'h23, 'h22, 'h21, 'h20};
        int idx = -1;
        for (int i = 0; i < 14; i++) if (op[i]) idx = i;
        if (idx == 0)
            return (32'd15 << 26) | (32'(rt) << 16) | 32'(imm);
        else if (idx >= 1 && idx <= 3)
            return (32'(rt) << 16) | (32'(rd) << 11) | (32'(sa) << 6) | 32'(funct_tab[idx]);
        else
            return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(funct_tab[idx]);
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " count"}, 32'(count_o), 32'd0);
        check({tag, " valid"}, 32'(inst_valid_o), 32'd0);
        check({tag, " inst"},  inst_o, 32'h0);
        check({tag, " err"},   32'(err_o), 32'd0);
        check({tag, " ready"}, 32'(req_ready_o), 32'd1);
    endtask

    logic [31:0] words [5];
    logic [31:0] q[$];

    initial begin
        rst = 1'b0;
        inst_ready_i = 1'b0;
        set_req(1'b0, '0, '0, '0, '0, '0, '0);

        vecs.push_back('{14'h2000, 5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 32'h0022_1820, 1'b0}); // add
        vecs.push_back('{14'h0008, 5'd7,  5'd5,  5'd4,  5'd3,  16'h0000, 32'h0005_20C0, 1'b0}); // sll
        vecs.push_back('{14'h0001, 5'd9,  5'd8,  5'd0,  5'd0,  16'h1234, 32'h3C08_1234, 1'b0}); // lui
        vecs.push_back('{14'h0010, 5'd31, 5'd0,  5'd31, 5'd5,  16'hFFFF, 32'h03E0_F827, 1'b0}); // nor
        vecs.push_back('{14'h0002, 5'd3,  5'd31, 5'd1,  5'd31, 16'h0000, 32'h001F_0FC3, 1'b0}); // sra
        vecs.push_back('{14'h0100, 5'd4,  5'd5,  5'd6,  5'd9,  16'h0000, 32'h0085_302B, 1'b0}); // sltu
        vecs.push_back('{14'h0003, 5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 32'h0000_0000, 1'b1});
        vecs.push_back('{14'h0000, 5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 32'h0000_0000, 1'b1});

        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_idle("reset");

        // Directed table: single request into an empty FIFO, then pop it.
        foreach (vecs[i]) begin
            set_req(1'b1, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sa, vecs[i].imm);
            @(negedge clk);
            req_valid_i = 1'b0;
            check($sformatf("vec%0d err", i),   32'(err_o), 32'(vecs[i].err));
            check($sformatf("vec%0d count", i), 32'(count_o), vecs[i].err ? 32'd0 : 32'd1);
            check($sformatf("vec%0d valid", i), 32'(inst_valid_o), vecs[i].err ? 32'd0 : 32'd1);
            check($sformatf("vec%0d word", i),  inst_o, vecs[i].word);
            inst_ready_i = 1'b1;
            @(negedge clk);
            inst_ready_i = 1'b0;
            check($sformatf("vec%0d after", i), 32'(count_o), 32'd0);
            check($sformatf("vec%0d errpulse", i), 32'(err_o), 32'd0);
        end

        // Full and drain: fifth request waits, accepted the cycle after the first pop.
        for (int i = 0; i < 5; i++) begin
            words[i] = model_word(14'h2000 >> i, 5'(i + 1), 5'(i + 2), 5'(i + 3), 5'(i), 16'(i));
        end
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 14'h2000 >> i, 5'(i + 1), 5'(i + 2), 5'(i + 3), 5'(i), 16'(i));
            @(negedge clk);
        end
        set_req(1'b1, 14'h2000 >> 4, 5'd5, 5'd6, 5'd7, 5'd4, 16'd4);
        check("full count", 32'(count_o), 32'd4);
        check("full ready", 32'(req_ready_o), 32'd0);
        check("full head", inst_o, words[0]);
        @(negedge clk);
        check("held count", 32'(count_o), 32'd4);
        check("held head", inst_o, words[0]);
        inst_ready_i = 1'b1;
        @(negedge clk);
        check("pop1 count", 32'(count_o), 32'd3);
        check("pop1 ready", 32'(req_ready_o), 32'd1);
        check("pop1 head", inst_o, words[1]);
        @(negedge clk);
        req_valid_i = 1'b0;
        check("pushpop count", 32'(count_o), 32'd3);
        check("pushpop head", inst_o, words[2]);
        for (int i = 3; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("drain%0d", i), inst_o, words[i]);
            check($sformatf("drain%0d count", i), 32'(count_o), 32'(5 - i));
        end
        @(negedge clk);
        inst_ready_i = 1'b0;
        check("drained count", 32'(count_o), 32'd0);
        check("drained inst", inst_o, 32'h0);

        // Reset with three words queued and a request presented.
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 14'h0040, 5'(i), 5'(i), 5'(i), 5'd0, 16'd0);
            @(negedge clk);
        end
        check("pre-reset count", 32'(count_o), 32'd3);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req_valid_i = 1'b0;
        check_idle("midreset");
        set_req(1'b1, 14'h2000, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0);
        @(negedge clk);
        req_valid_i = 1'b0;
        check("post-reset word", inst_o, 32'h0022_1820);
        check("post-reset count", 32'(count_o), 32'd1);
        inst_ready_i = 1'b1;
        @(negedge clk);
        inst_ready_i = 1'b0;

        // Random traffic against a queue model.
        begin
            logic exp_err = 1'b0;
            logic hold = 1'b0;
            q.delete();
            for (int cyc = 0; cyc < 1500; cyc++) begin
                logic rdy, acc, pop, legal;
                check("rnd count", 32'(count_o), 32'(q.size()));
                check("rnd valid", 32'(inst_valid_o), 32'(q.size() != 0));
                check("rnd inst",  inst_o, (q.size() != 0) ? q[0] : 32'h0);
                check("rnd ready", 32'(req_ready_o), 32'(q.size() != 4));
                check("rnd err",   32'(err_o), 32'(exp_err));
                if (!hold) begin
                    logic [13:0] op;
                    op = ($urandom_range(99) < 85) ? (14'h0001 << $urandom_range(13))
                                                   : 14'($urandom);
                    set_req($urandom_range(2) != 0, op, 5'($urandom), 5'($urandom),
                            5'($urandom), 5'($urandom), 16'($urandom));
                end
                inst_ready_i = 1'($urandom);
                rdy   = (q.size() != 4);
                acc   = req_valid_i && rdy;
                pop   = inst_ready_i && (q.size() != 0);
                legal = (popcount14(aluop_i) == 1);
                if (pop) void'(q.pop_front());
                if (acc && legal) q.push_back(model_word(aluop_i, rs_i, rt_i, rd_i, sa_i, imm_i));
                exp_err = acc && !legal;
                hold    = req_valid_i && !acc;
                @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder and issue buffer, the inverse of the ID-stage decoder. It accepts decoded operation requests: a one-hot ALU op plus register addresses, shift amount and immediate. It assembles each request into a 32-bit MIPS instruction word, queues the words in a small FIFO, and presents them to the decode stage over a valid/ready handshake. It serves as the self-test instruction source in front of `id` and as the round-trip checker for the decoder.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: reset, synchronous and active-low.
- `req_valid_i`  in  1: a request is present.
- `req_ready_o`  out  1: the encoder can accept a request.
- `aluop_i`  in  14 (`Aluop_OnehotBus`): one-hot op. Bit 13 is add, then addu, sub, subu, slt, sltu, and, or, xor, nor, sll, srl, sra; bit 0 is lui.
- `rs_i`, `rt_i`, `rd_i`  in  5 each: register addresses.
- `sa_i`  in  5: shift amount.
- `imm_i`  in  16: lui immediate.
- `inst_valid_o`  out  1: the head word is valid.
- `inst_ready_i`  in  1: the decode side accepts the head word.
- `inst_o`  out  32: the head instruction word.
- `err_o`  out  1: one-cycle pulse when a request has an illegal op.
- `count_o`  out  clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **Accept:** a request is accepted when `req_valid_i && req_ready_o` at a rising edge of `clk`. `req_ready_o = (count_o != DEPTH)`.
- **Legality:** an op is legal when exactly one bit of `aluop_i` is set.
  - An accepted illegal request is dropped, not enqueued.
  - `err_o` is high for exactly the next cycle.
- **R-type arithmetic/logic ops** (add through nor):
  - Word = {6'b000000, rs, rt, rd, 5'b00000, funct}.
  - The sa field is forced to 0.
  - funct values: add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, sltu 0x2B.
- **Shift ops:**
  - Word = {6'b000000, 5'b00000, rt, rd, sa, funct}.
  - The rs field is forced to 0; `rs_i` is ignored.
  - funct values: sll 0x00, srl 0x02, sra 0x03.
- **lui:**
  - Word = {6'b001111, 5'b00000, rt, imm}.
  - `rs_i`, `rd_i` and `sa_i` are ignored.
- **Pop:** the head word is removed when `inst_valid_o && inst_ready_i`. `inst_valid_o = (count_o != 0)`.
- **Idle output:** `inst_o` is 32'h0000_0000 (nop) whenever `inst_valid_o` is low.
- **Ordering:** words leave in strict acceptance order. Read and write pointers wrap modulo DEPTH.

## Timing
- **Reset:** when `rst` is low at a rising edge, the following take effect on the next cycle:
  - `count_o` = 0, `inst_valid_o` = 0, `inst_o` = 0.
  - `err_o` = 0, `req_ready_o` = 1.
  - Both pointers are 0.
  - Reset mid-operation discards all queued words and any request presented in that cycle.
- **Latency:** an accepted legal request into an empty FIFO appears on `inst_o`, with `inst_valid_o` high, in the cycle after acceptance. There is no combinational bypass from request to output.
- **Simultaneous push and pop:**
  - When `0 < count_o < DEPTH`, both happen and `count_o` is unchanged.
  - When empty, only the push can occur.
  - When full, `req_ready_o` is low, so only the pop occurs. Ready rises in the next cycle, not in the same cycle.
- **Illegal request with a pop in the same cycle:** the pop proceeds, and `count_o` decrements by 1.
- **Full:** a request held with `req_valid_i` high while full waits without loss. It must be presented unchanged until accepted.
- **Output stability:** `inst_o` is stable while `inst_valid_o && !inst_ready_i`.

## Structure
- **Shared package/defines file:**
  - `Aluop_OnehotBus` and the one-hot bit indices (`AluopAdd` through `AluopLui`).
  - The funct constants (`FuncAdd` through `FuncSra`), `OpZero` and `OpLui` (6'b001111).
  - `InstBus`, `RegAddrBus`, `ZeroWord`.
  - All of these are shared with `id` so that the encode and decode tables come from one source.
- **Sub-module `inst_fifo`:** a parameterised synchronous FIFO with push/pop, `count`, full/empty and active-low synchronous reset.
- **Encoder logic:** a combinational function local to `inst_encoder`.

## Test plan
- **add:** reset, then push add with rs=1, rt=2, rd=3 → one cycle later `inst_valid_o`=1 and `inst_o`=32'h0022_1820.
- **sll:** push sll with rs=7, rt=5, rd=4, sa=3 → `inst_o`=32'h0005_20C0 (rs masked).
- **lui:** push lui with rt=8, imm=16'h1234, rs=9 → `inst_o`=32'h3C08_1234.
- **Illegal op:** push `aluop_i`=14'h0003, then 14'h0000 → `err_o` pulses for one cycle each time, and `count_o` stays 0.
- **Full and drain:** DEPTH=4, `inst_ready_i`=0, push 5 legal ops → `req_ready_o` falls after the 4th. Then raise `inst_ready_i` → words drain in order, and the 5th is accepted the cycle after the first pop.
- **Reset mid-operation:** 3 entries queued, drive `rst` low for one edge → the next cycle shows `count_o`=0, `inst_valid_o`=0 and `inst_o`=0. A subsequent push encodes correctly.
